regfile_write_arbiter: RTL

- Shares the register file's single write port (WriteRegister/WriteData/RegWrite) between two producers.
- Requester A is the main pipeline writeback stage; requester B is a long-latency unit (multiplier or load return).
- Arbitration is fixed-priority: A wins, but a starvation limit forces a grant to B.
- Drives the register file write port from registered outputs, one cycle after the grant; X31 writes are absorbed.

---
 rtl/regfile_write_arbiter.sv | 79 +++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-producer arbiter for the register file's single write port.
// Fixed priority to A with a starvation limit for B; the port is driven from registered outputs.
module regfile_write_arbiter #(
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [4:0]        a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [4:0]        b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic [4:0]        WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    output logic              RegWrite,
    output logic              x31_drop
);

    localparam int unsigned     CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]  b_wait;
    logic              b_forced;
    logic              grant_a;
    logic              grant_b;
    logic [4:0]        sel_reg;
    logic [DATA_W-1:0] sel_data;

    always_comb begin
        b_forced = (b_wait >= LIMIT);
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        if (!reset) begin
            if (a_valid && b_valid) begin
                grant_b = b_forced;
                grant_a = !b_forced;
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
        sel_reg  = grant_b ? b_reg  : a_reg;
        sel_data = grant_b ? b_data : a_data;
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Counts consecutive cycles B lost to A; saturates so B stays forced until it wins.
    always_ff @(posedge clk) begin
        if (reset || !b_valid || grant_b) begin
            b_wait <= '0;
        end else if (grant_a && (b_wait != LIMIT)) begin
            b_wait <= b_wait + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            WriteRegister <= '0;
            WriteData     <= '0;
            RegWrite      <= 1'b0;
            x31_drop      <= 1'b0;
        end else if (grant_a || grant_b) begin
            WriteRegister <= sel_reg;
            WriteData     <= sel_data;
            RegWrite      <= (sel_reg != 5'd31);
            x31_drop      <= (sel_reg == 5'd31);
        end else begin
            RegWrite      <= 1'b0;
            x31_drop      <= 1'b0;
        end
    end

endmodule
